ghost_sprite_ctrl: RTL and testbench

- Sprite-layer controller that drives the ghost bitmap RAM: one write port, one read port with 1-cycle registered read, 2-bit pixel indices.
- Sequences RAM reads from the video scan position and overlays the palette-mapped ghost pixel onto the incoming RGB stream.
- Routes CPU MMIO writes into the RAM and into position, animation and palette registers.
- Manages 4 animation frames of 16x16, sharing one 1024-entry RAM.

---
 rtl/ghost_pkg.sv | 36 +++
 rtl/ghost_anim_fsm.sv | 87 ++++++++
 rtl/ghost_sprite_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ghost_sprite_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost sprite layer.
// Holds MMIO register offsets, ctrl bit positions, sprite geometry,
// palette constants and the animation state type.
package ghost_pkg;

  localparam int SPRITE_DIM = 16;
  localparam int N_FRAMES   = 4;

  // Register offsets selected by addr[2:0] when addr[13]=1
  localparam logic [2:0] REG_X0     = 3'd0;
  localparam logic [2:0] REG_Y0     = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_PERIOD = 3'd3;
  localparam logic [2:0] REG_COLOR  = 3'd4;

  // ctrl register layout
  localparam int CTRL_W         = 5;
  localparam int CTRL_BYPASS    = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_MFRAME_LO = 2;
  localparam int CTRL_MIRROR    = 4;

  localparam logic [CTRL_W-1:0] CTRL_RESET   = 5'b00001;
  localparam logic [5:0]        PERIOD_RESET = 6'd8;

  // Palette (12-bit 4:4:4)
  localparam logic [11:0] COLOR_RESET = 12'hF00;
  localparam logic [11:0] PAL_WHITE   = 12'hFFF;
  localparam logic [11:0] PAL_BLUE    = 12'h00F;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } anim_state_t;

endpackage

// File: rtl/ghost_anim_fsm.sv
// Animation frame sequencer for the ghost sprite.
// Ports:
//   clk, reset     - clock, async active-high reset
//   frame_start    - one pulse per video frame
//   auto_anim      - auto-animate enable (value becoming active this frame_start)
//   manual_frame   - frame shown in manual mode (value becoming active)
//   period         - frame_start pulses per animation step (0 behaves as 1)
//   frame_idx      - current animation frame, top bits of the RAM read address
//
// state  | meaning
// MANUAL | frame_idx follows manual_frame at every frame_start, anim_cnt = 0
// AUTO   | anim_cnt counts frame_starts, frame_idx steps 0..3 every period
//
// All decisions are taken on frame_start, using the control values being
// loaded into the active copies on that same edge.
module ghost_anim_fsm
  import ghost_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       auto_anim,
  input  logic [1:0] manual_frame,
  input  logic [5:0] period,
  output logic [1:0] frame_idx
);

  anim_state_t state, state_n;
  logic [5:0]  anim_cnt, cnt_n, last_cnt;
  logic [1:0]  idx_n;

  // Terminal count is max(period,1)-1
  assign last_cnt = (period == 6'd0) ? 6'd0 : period - 6'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= MANUAL;
      anim_cnt  <= 6'd0;
      frame_idx <= 2'd0;
    end else begin
      state     <= state_n;
      anim_cnt  <= cnt_n;
      frame_idx <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    if (frame_start) begin
      case (state)
        MANUAL: if (auto_anim)  state_n = AUTO;
        AUTO:   if (!auto_anim) state_n = MANUAL;
        default: state_n = MANUAL;
      endcase
    end
  end

  always_comb begin
    cnt_n = anim_cnt;
    idx_n = frame_idx;
    if (frame_start) begin
      case (state)
        MANUAL: begin
          cnt_n = 6'd0;
          if (!auto_anim) idx_n = manual_frame;
        end
        AUTO: begin
          if (!auto_anim) begin
            cnt_n = 6'd0;
            idx_n = manual_frame;
          end else if (anim_cnt >= last_cnt) begin
            // >= so a period shortened mid-count still wraps
            cnt_n = 6'd0;
            idx_n = frame_idx + 2'd1;
          end else begin
            cnt_n = anim_cnt + 6'd1;
          end
        end
        default: begin
          cnt_n = 6'd0;
          idx_n = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ghost_sprite_ctrl.sv
// Ghost sprite layer: MMIO decode, shadowed position/ctrl registers,
// ghost RAM read sequencing and 2-cycle RGB overlay pipeline.
// Optional macro GHOST_MIRROR_EN: enables horizontal mirroring via ctrl.mirror.
// Ports:
//   clk, reset           - clock, async active-high reset
//   x, y                 - current scan position
//   frame_start          - pulse at pixel (0,0); loads active registers
//   cs, write, addr,
//   wr_data              - write-only MMIO slot
//   si_rgb / so_rgb      - video in from previous layer / out to next layer
//   ram_we, ram_addr_w,
//   ram_din              - ghost RAM write port
//   ram_addr_r, ram_dout - ghost RAM read port (1-cycle registered read)
module ghost_sprite_ctrl
  import ghost_pkg::*;
#(
  parameter int         CD         = 12,
  parameter int         ADDR_WIDTH = 10,
  parameter logic [1:0] KEY_IDX    = 2'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_start,
  input  logic                  cs,
  input  logic                  write,
  input  logic [13:0]           addr,
  input  logic [31:0]           wr_data,
  input  logic [CD-1:0]         si_rgb,
  output logic [CD-1:0]         so_rgb,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [1:0]            ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [1:0]            ram_dout
);

  logic bus_wr, reg_wr;
  logic wr_x0, wr_y0, wr_ctrl, wr_period, wr_color;

  logic [10:0]       x0_s, y0_s, x0_a, y0_a, x0_l, y0_l;
  logic [CTRL_W-1:0] ctrl_s, ctrl_a, ctrl_l;
  logic [5:0]        period_s, period_l;
  logic [CD-1:0]     body_color;
  logic [1:0]        frame_idx;

  logic [11:0]   x_e, y_e, x0_e, y0_e;
  logic          hit, hit_d1, byp_d1;
  logic [3:0]    xrel, yrel, xcol;
  logic [CD-1:0] si_d1, pix_n;
  logic          unused_ok;

  // Bus decode
  assign bus_wr     = cs & write;
  assign reg_wr     = bus_wr & addr[13];
  assign ram_we     = bus_wr & ~addr[13];
  assign ram_addr_w = ADDR_WIDTH'(addr[9:0]);
  assign ram_din    = wr_data[1:0];

  assign wr_x0     = reg_wr && (addr[2:0] == REG_X0);
  assign wr_y0     = reg_wr && (addr[2:0] == REG_Y0);
  assign wr_ctrl   = reg_wr && (addr[2:0] == REG_CTRL);
  assign wr_period = reg_wr && (addr[2:0] == REG_PERIOD);
  assign wr_color  = reg_wr && (addr[2:0] == REG_COLOR);

  // Values the active copies take on frame_start; a write in the same
  // cycle wins over the staged copy.
  assign x0_l     = wr_x0     ? wr_data[10:0]       : x0_s;
  assign y0_l     = wr_y0     ? wr_data[10:0]       : y0_s;
  assign ctrl_l   = wr_ctrl   ? wr_data[CTRL_W-1:0] : ctrl_s;
  assign period_l = wr_period ? wr_data[5:0]        : period_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_s       <= 11'd0;
      y0_s       <= 11'd0;
      ctrl_s     <= CTRL_RESET;
      period_s   <= PERIOD_RESET;
      body_color <= CD'(COLOR_RESET);
    end else begin
      if (wr_x0)     x0_s       <= wr_data[10:0];
      if (wr_y0)     y0_s       <= wr_data[10:0];
      if (wr_ctrl)   ctrl_s     <= wr_data[CTRL_W-1:0];
      if (wr_period) period_s   <= wr_data[5:0];
      if (wr_color)  body_color <= wr_data[CD-1:0];
    end
  end

  // Period and auto/manual_frame are consumed only at frame_start, so the
  // FSM samples the loading values directly instead of an active copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_a   <= 11'd0;
      y0_a   <= 11'd0;
      ctrl_a <= CTRL_RESET;
    end else if (frame_start) begin
      x0_a   <= x0_l;
      y0_a   <= y0_l;
      ctrl_a <= ctrl_l;
    end
  end

  ghost_anim_fsm u_anim (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .auto_anim    (ctrl_l[CTRL_AUTO]),
    .manual_frame (ctrl_l[CTRL_MFRAME_LO +: 2]),
    .period       (period_l),
    .frame_idx    (frame_idx)
  );

  // Stage 0: 12-bit compare so a sprite near column 2047 clips, not wraps
  assign x_e  = {1'b0, x};
  assign y_e  = {1'b0, y};
  assign x0_e = {1'b0, x0_a};
  assign y0_e = {1'b0, y0_a};
  assign hit  = (x_e >= x0_e) && (x_e < x0_e + 12'd16) &&
                (y_e >= y0_e) && (y_e < y0_e + 12'd16);

  assign xrel = x[3:0] - x0_a[3:0];
  assign yrel = y[3:0] - y0_a[3:0];

`ifdef GHOST_MIRROR_EN
  assign xcol = ctrl_a[CTRL_MIRROR] ? (4'hF - xrel) : xrel;
`else
  assign xcol = xrel;
`endif

  assign ram_addr_r = ADDR_WIDTH'({frame_idx, yrel, xcol});

  // Stage 1: align hit/bypass/video with the RAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_d1 <= 1'b0;
      byp_d1 <= 1'b1;
      si_d1  <= '0;
    end else begin
      hit_d1 <= hit;
      byp_d1 <= ctrl_a[CTRL_BYPASS];
      si_d1  <= si_rgb;
    end
  end

  always_comb begin
    pix_n = si_d1;
    if (!byp_d1 && hit_d1 && (ram_dout != KEY_IDX)) begin
      case (ram_dout)
        2'd1:    pix_n = body_color;
        2'd2:    pix_n = CD'(PAL_WHITE);
        2'd3:    pix_n = CD'(PAL_BLUE);
        default: pix_n = si_d1;
      endcase
    end
  end

  // Stage 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) so_rgb <= '0;
    else       so_rgb <= pix_n;
  end

  assign unused_ok = ^{addr[12:10], wr_data, ctrl_a[CTRL_W-1:1]};

endmodule

// File: tb/tb_ghost_sprite_ctrl.sv
module tb_ghost_sprite_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        frame_start, cs, write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [11:0] si_rgb, so_rgb;
  logic        ram_we;
  logic [9:0]  ram_addr_w, ram_addr_r;
  logic [1:0]  ram_din, ram_dout;

  int checks = 0;
  int failures = 0;

  ghost_sprite_ctrl dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .si_rgb(si_rgb), .so_rgb(so_rgb), .ram_we(ram_we), .ram_addr_w(ram_addr_w),
    .ram_din(ram_din), .ram_addr_r(ram_addr_r), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Ghost RAM driven by the DUT ports
  logic [1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_w] <= ram_din;
    ram_dout <= mem[ram_addr_r];
  end

  // Reference model state
  logic [1:0]  mref [1024];
  int          m_x0_s, m_y0_s, m_per_s, m_x0, m_y0;
  logic [4:0]  m_ctrl_s, m_ctrl;
  logic [11:0] m_color;
  int          m_frame, m_cnt;
  bit          m_auto;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_x0_s = 0; m_y0_s = 0; m_ctrl_s = 5'b00001; m_per_s = 8;
    m_x0 = 0; m_y0 = 0; m_ctrl = 5'b00001;
    m_color = 12'hF00; m_frame = 0; m_cnt = 0; m_auto = 0;
  endtask

  task automatic model_reg(input logic [2:0] off, input logic [31:0] d);
    case (off)
      3'd0: m_x0_s = int'(d[10:0]);
      3'd1: m_y0_s = int'(d[10:0]);
      3'd2: m_ctrl_s = d[4:0];
      3'd3: m_per_s = int'(d[5:0]);
      3'd4: m_color = d[11:0];
      default: ;
    endcase
  endtask

  // Frame-level animation rule: in auto mode the frame steps once every
  // max(period,1) frame_starts; entering auto keeps the current frame.
  task automatic model_frame();
    int pmax;
    m_x0 = m_x0_s; m_y0 = m_y0_s; m_ctrl = m_ctrl_s;
    pmax = (m_per_s == 0) ? 1 : m_per_s;
    if (!m_auto) begin
      if (m_ctrl[1]) m_auto = 1;
      else m_frame = int'(m_ctrl[3:2]);
    end else if (!m_ctrl[1]) begin
      m_auto = 0; m_cnt = 0; m_frame = int'(m_ctrl[3:2]);
    end else begin
      m_cnt++;
      if (m_cnt >= pmax) begin
        m_cnt = 0;
        m_frame = (m_frame + 1) % 4;
      end
    end
  endtask

  function automatic int mirror_col(int xr);
`ifdef GHOST_MIRROR_EN
    if (m_ctrl[4]) return 15 - xr;
`endif
    return xr;
  endfunction

  function automatic logic [11:0] exp_pix(int px, int py, logic [11:0] si);
    int xr, yr;
    logic [1:0] v;
    if (m_ctrl[0]) return si;
    if (!(px >= m_x0 && px < m_x0 + 16 && py >= m_y0 && py < m_y0 + 16)) return si;
    xr = mirror_col(px - m_x0);
    yr = py - m_y0;
    v = mref[m_frame * 256 + yr * 16 + xr];
    case (v)
      2'd0: return si;
      2'd1: return m_color;
      2'd2: return 12'hFFF;
      default: return 12'h00F;
    endcase
  endfunction

  task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
    cs = 1; write = 1; addr = a; wr_data = d;
    #1;
    if (!a[13]) begin
      chk("ram_we", 32'(ram_we), 32'd1);
      chk("ram_addr_w", 32'(ram_addr_w), 32'(a[9:0]));
      chk("ram_din", 32'(ram_din), 32'(d[1:0]));
      mref[a[9:0]] = d[1:0];
    end else begin
      chk("ram_we_on_reg", 32'(ram_we), 32'd0);
      model_reg(a[2:0], d);
    end
    @(posedge clk); #1;
    cs = 0; write = 0;
  endtask

  task automatic reg_write(input logic [2:0] off, input logic [31:0] d);
    bus_write({1'b1, 10'd0, off}, d);
  endtask

  task automatic frame_pulse();
    frame_start = 1;
    tick();
    frame_start = 0;
    model_frame();
  endtask

  task automatic frame_with_write(input logic [2:0] off, input logic [31:0] d);
    cs = 1; write = 1; addr = {1'b1, 10'd0, off}; wr_data = d; frame_start = 1;
    tick();
    cs = 0; write = 0; frame_start = 0;
    model_reg(off, d);
    model_frame();
  endtask

  task automatic pix_check(input string tag, input int px, input int py, input logic [11:0] si);
    logic [11:0] e;
    x = 11'(px); y = 11'(py); si_rgb = si;
    e = exp_pix(px, py, si);
    tick(); tick();
    chk(tag, 32'(so_rgb), 32'(e));
  endtask

  task automatic addr_check(input string tag, input int px, input int py);
    int e;
    x = 11'(px); y = 11'(py);
    #1;
    e = m_frame * 256 + ((py - m_y0) & 15) * 16 + mirror_col((px - m_x0) & 15);
    chk(tag, 32'(ram_addr_r), 32'(e));
  endtask

  // Back-to-back random pixels near (bx,by); output checked 2 cycles later
  task automatic stream(input string tag, input int n, input int bx, input int by);
    logic [11:0] q[$];
    int px, py;
    logic [11:0] si;
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) chk(tag, 32'(so_rgb), 32'(q.pop_front()));
      if (i < n) begin
        px = (bx + int'($urandom_range(0, 23)) - 4) & 2047;
        py = (by + int'($urandom_range(0, 23)) - 4) & 2047;
        si = 12'($urandom);
        x = 11'(px); y = 11'(py); si_rgb = si;
        q.push_back(exp_pix(px, py, si));
      end
      tick();
    end
  endtask

  task automatic frame_check(input string tag);
    chk(tag, 32'(ram_addr_r[9:8]), 32'(m_frame));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 2'd0;
      mref[i] = 2'd0;
    end
    reset = 1; x = 0; y = 0; frame_start = 0; cs = 0; write = 0;
    addr = 0; wr_data = 0; si_rgb = 12'h5A5;
    model_reset();
    tick(); tick();
    chk("reset_so_rgb", 32'(so_rgb), 32'd0);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_frame", 32'(ram_addr_r[9:8]), 32'd0);
    reset = 0;
    tick();

    pix_check("bypass_after_reset", 3, 4, 12'h123);

    for (int i = 0; i < 1024; i++) bus_write(14'(i), 32'($urandom));
    bus_write(14'd0, 32'd1);
    bus_write(14'd17, 32'd2);
    bus_write(14'd34, 32'd0);

    reg_write(3'd0, 32'd100);
    reg_write(3'd1, 32'd50);
    reg_write(3'd2, 32'd0);
    pix_check("staged_not_active", 100, 50, 12'h0C3);
    frame_pulse();
    pix_check("body_at_origin", 100, 50, 12'h0C3);
    pix_check("left_of_sprite", 99, 50, 12'h0C3);
    pix_check("white_at_101_51", 101, 51, 12'h321);
    pix_check("key_transparent", 102, 52, 12'h777);
    pix_check("right_edge_out", 116, 50, 12'h777);

    reg_write(3'd4, 32'h0A5);
    pix_check("color_immediate", 100, 50, 12'h111);

    reg_write(3'd0, 32'd200);
    pix_check("x0_held_old", 100, 50, 12'h222);
    pix_check("x0_new_not_yet", 200, 50, 12'h222);
    bus_write(14'd0, 32'd3);
    frame_pulse();
    pix_check("x0_new_active", 200, 50, 12'h333);
    pix_check("x0_old_gone", 100, 50, 12'h333);

    stream("stream_basic", 300, 200, 50);

    frame_with_write(3'd0, 32'd300);
    pix_check("coincident_write", 300, 50, 12'h444);
    stream("stream_coincident", 100, 300, 50);

    reg_write(3'd0, 32'd2040);
    reg_write(3'd1, 32'd10);
    frame_pulse();
    for (int i = 0; i < 8; i++) bus_write(14'(10 * 16 + i), 32'd3);
    pix_check("clip_2040", 2040, 10, 12'h555);
    pix_check("clip_2047", 2047, 10, 12'h555);
    pix_check("clip_no_wrap_0", 0, 10, 12'h555);
    pix_check("clip_no_wrap_7", 7, 10, 12'h555);
    stream("stream_clip", 300, 2040, 10);

    reg_write(3'd0, 32'd64);
    reg_write(3'd1, 32'd32);
    reg_write(3'd2, 32'h10);
    frame_pulse();
    addr_check("mirror_addr", 64, 32);
    tick();
    stream("stream_mirror", 200, 64, 32);

    reg_write(3'd2, 32'h1);
    frame_pulse();
    stream("stream_bypass", 60, 64, 32);

    reg_write(3'd3, 32'd3);
    reg_write(3'd2, 32'h2);
    frame_pulse();
    frame_check("auto_enter");
    for (int i = 0; i < 10; i++) begin
      frame_pulse();
      frame_check("auto_p3");
    end
    stream("stream_auto", 100, 64, 32);
    reg_write(3'd3, 32'd0);
    for (int i = 0; i < 6; i++) begin
      frame_pulse();
      frame_check("auto_p0");
    end
    reg_write(3'd2, 32'hC);
    frame_pulse();
    frame_check("manual_return");
    stream("stream_frame3", 100, 64, 32);

    x = 64; y = 32; si_rgb = 12'h9AB;
    tick(); tick();
    #3 reset = 1;
    #1;
    chk("midframe_reset_so", 32'(so_rgb), 32'd0);
    chk("midframe_reset_frame", 32'(ram_addr_r[9:8]), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    pix_check("after_reset_bypass", 64, 32, 12'hBEE);
    frame_pulse();
    pix_check("after_reset_frame", 0, 0, 12'hCAB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
